// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU), one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor short-circuits to a zero result.
module div_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_in,
  input  logic        annul_in,
  input  logic        signed_div_in,
  input  logic [31:0] opdata1_in,
  input  logic [31:0] opdata2_in,
  output logic [63:0] result_out,
  output logic        ready_out,
  output logic        stall_req_out
);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] rem_r, quo_r, dsr_r;
  logic        neg_q_r, neg_r_r;
  logic [32:0] partial;
  logic [31:0] rem_step, quo_step;
  logic [31:0] op1_abs, op2_abs;
  logic        launch;

  assign launch  = start_in & ~annul_in;
  assign op1_abs = (signed_div_in && opdata1_in[31]) ? 32'(-opdata1_in) : opdata1_in;
  assign op2_abs = (signed_div_in && opdata2_in[31]) ? 32'(-opdata2_in) : opdata2_in;

  // The dividend magnitude sits in quo_r and is shifted out MSB-first into the
  // partial remainder while quotient bits are shifted in from the bottom.
  always_comb begin
    partial  = {rem_r, quo_r[31]};
    rem_step = partial[31:0];
    quo_step = {quo_r[30:0], 1'b0};
    if (partial >= {1'b0, dsr_r}) begin
      rem_step = 32'(partial - {1'b0, dsr_r});
      quo_step = {quo_r[30:0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FREE: begin
        if (launch) begin
`ifdef DIV_ZERO_FAST_EN
          state_nxt = (opdata2_in == '0) ? BY_ZERO : ON;
`else
          state_nxt = ON;
`endif
        end
      end
      BY_ZERO: state_nxt = annul_in ? FREE : END;
      ON: begin
        if (annul_in || !start_in) state_nxt = FREE;
        else if (cnt == 6'd31)     state_nxt = END;
      end
      END:     state_nxt = start_in ? END : FREE;
      default: state_nxt = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FREE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      rem_r      <= '0;
      quo_r      <= '0;
      dsr_r      <= '0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      result_out <= '0;
      ready_out  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          ready_out  <= 1'b0;
          result_out <= '0;
          if (launch) begin
            cnt     <= '0;
            rem_r   <= '0;
            quo_r   <= op1_abs;
            dsr_r   <= op2_abs;
            neg_q_r <= signed_div_in & (opdata1_in[31] ^ opdata2_in[31]);
            neg_r_r <= signed_div_in & opdata1_in[31];
          end
        end
        BY_ZERO: begin
          rem_r <= '0;
          quo_r <= '0;
        end
        ON: begin
          if (state_nxt == ON) begin
            rem_r <= rem_step;
            quo_r <= quo_step;
            cnt   <= cnt + 6'd1;
          end else if (state_nxt == END) begin
            rem_r <= neg_r_r ? 32'(-rem_step) : rem_step;
            quo_r <= neg_q_r ? 32'(-quo_step) : quo_step;
            cnt   <= cnt + 6'd1;
          end
        end
        END: begin
          if (start_in) begin
            ready_out  <= 1'b1;
            result_out <= {rem_r, quo_r};
          end else begin
            ready_out  <= 1'b0;
            result_out <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_req_out = rst_n & (((state == FREE) & launch) | (state == ON) | (state == BY_ZERO));

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands
// compared against an arithmetic reference model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_in, annul_in, signed_div_in;
  logic [31:0] opdata1_in, opdata2_in;
  logic [63:0] result_out;
  logic        ready_out, stall_req_out;

  int nerr = 0;
  int nchk = 0;

  div_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_in      (start_in),
    .annul_in      (annul_in),
    .signed_div_in (signed_div_in),
    .opdata1_in    (opdata1_in),
    .opdata2_in    (opdata2_in),
    .result_out    (result_out),
    .ready_out     (ready_out),
    .stall_req_out (stall_req_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: DIVU semantics with x/0 = all-ones quotient, remainder = x;
  // DIV works on magnitudes, quotient sign = XOR of signs, remainder takes dividend sign.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (mb == 0) begin q = 32'hFFFF_FFFF; r = ma; end
    else begin q = ma / mb; r = ma % mb; end
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction

  function automatic int latency(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 0) ? 2 : 33;
`else
    return 33;
`endif
  endfunction

  function automatic logic [63:0] expect_res(input logic s, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 0) return 64'h0;
`endif
    return model(s, a, b);
  endfunction

  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
    int n, stl, lat;
    logic got;
    n = 0; stl = 0; got = 1'b0;
    lat = latency(b);
    @(negedge clk);
    annul_in = 1'b0; signed_div_in = s; opdata1_in = a; opdata2_in = b; start_in = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (ready_out) begin got = 1'b1; break; end
      if (stall_req_out) stl++;
      @(posedge clk); n++;
      @(negedge clk);
    end
    chk({tag, "_done"},    64'(got), 64'd1);
    chk({tag, "_latency"}, 64'(n - 1), 64'(lat));
    chk({tag, "_stalls"},  64'(stl), 64'(lat));
    chk({tag, "_result"},  result_out, exp);
    chk({tag, "_stall_end"}, 64'(stall_req_out), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_hold_rdy"}, 64'(ready_out), 64'd1);
    chk({tag, "_hold_res"}, result_out, exp);
    @(negedge clk);
    start_in = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_drop_rdy"}, 64'(ready_out), 64'd0);
    chk({tag, "_drop_res"}, result_out, 64'd0);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;

    rst_n = 1'b0; start_in = 1'b1; annul_in = 1'b0; signed_div_in = 1'b0;
    opdata1_in = 32'd10; opdata2_in = 32'd3;
    #1;
    chk("rst_stall", 64'(stall_req_out), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd0);
    chk("rst_result", result_out, 64'd0);
    #12;
    start_in = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    run_div("div_m7_2",  1'b1, -32'sd7, 32'd2,  64'hFFFF_FFFF_FFFF_FFFD);
    run_div("div_7_m2",  1'b1, 32'd7, -32'sd2,  64'h0000_0001_FFFF_FFFD);
    run_div("div_wrap",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
`ifdef DIV_ZERO_FAST_EN
    run_div("divu_5_0",  1'b0, 32'd5, 32'd0, 64'h0);
`else
    run_div("divu_5_0",  1'b0, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF);
`endif

    // Annul on the 10th ON cycle, then an immediate new divide.
    @(negedge clk);
    signed_div_in = 1'b0; opdata1_in = 32'd100; opdata2_in = 32'd7; start_in = 1'b1;
    for (int k = 0; k < 10; k++) @(posedge clk);
    #1;
    chk("annul_rdy_before", 64'(ready_out), 64'd0);
    chk("annul_stall_on", 64'(stall_req_out), 64'd1);
    @(negedge clk); annul_in = 1'b1;
    @(posedge clk); #1;
    chk("annul_rdy", 64'(ready_out), 64'd0);
    chk("annul_res", result_out, 64'd0);
    chk("annul_free_stall", 64'(stall_req_out), 64'd0);
    run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h0000_0000_0000_0003);

    // Reset in the middle of an operation.
    @(negedge clk);
    signed_div_in = 1'b0; opdata1_in = 32'd50; opdata2_in = 32'd3; start_in = 1'b1;
    for (int k = 0; k < 5; k++) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midrst_stall", 64'(stall_req_out), 64'd0);
    chk("midrst_rdy", 64'(ready_out), 64'd0);
    chk("midrst_res", result_out, 64'd0);
    @(negedge clk); rst_n = 1'b1; start_in = 1'b0;
    run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF);

    // Reset while a result is being presented.
    @(negedge clk);
    signed_div_in = 1'b0; opdata1_in = 32'd6; opdata2_in = 32'd4; start_in = 1'b1;
    for (int k = 0; k < 34; k++) @(posedge clk);
    #1;
    chk("endrst_pre_rdy", 64'(ready_out), 64'd1);
    chk("endrst_pre_res", result_out, 64'h0000_0002_0000_0001);
    rst_n = 1'b0; #1;
    chk("endrst_rdy", 64'(ready_out), 64'd0);
    chk("endrst_res", result_out, 64'd0);
    @(negedge clk); rst_n = 1'b1; start_in = 1'b0;

    // start and annul together in FREE must not launch.
    @(negedge clk); start_in = 1'b1; annul_in = 1'b1; #1;
    chk("both_stall", 64'(stall_req_out), 64'd0);
    @(posedge clk); #1;
    chk("both_stall_after", 64'(stall_req_out), 64'd0);
    @(negedge clk); start_in = 1'b0; annul_in = 1'b0; #1;
    chk("both_still_free", 64'(stall_req_out), 64'd0);

    for (int i = 0; i < 14; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      if (i % 5 == 3) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_div($sformatf("rnd%0d", i), s, a, b, expect_res(s, a, b));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have these ports: clk, input, 1 bit, rising-edge clock.
REQ-003 SHALL have these ports: rst_n, input, 1 bit, async active-low reset.
REQ-004 SHALL have these ports: start_in, input, 1 bit, EX stage requests a divide; held high until the result is consumed.
REQ-005 SHALL have these ports: annul_in, input, 1 bit, cancels any operation in flight (e.g. a flushed branch shadow).
REQ-006 SHALL have these ports: signed_div_in, input, 1 bit, 1 = DIV, 0 = DIVU.
REQ-007 SHALL have these ports: opdata1_in, input, REG_DATA_WIDTH (32), dividend.
REQ-008 SHALL have these ports: opdata2_in, input, REG_DATA_WIDTH (32), divisor.
REQ-009 SHALL have these ports: result_out, output, 64 bits, {remainder[63:32] (HI), quotient[31:0] (LO)}.
REQ-010 SHALL have these ports: ready_out, output, 1 bit, result_out valid.
REQ-011 SHALL have these ports: stall_req_out, output, 1 bit, pipeline stall request to the control unit.

Function
REQ-012 SHALL implement the FSM states FREE, BY_ZERO, ON and END.
REQ-013 SHALL latch the operands, signed_div_in and a 6-bit counter (cleared to 0) on entry to ON or BY_ZERO; inputs SHALL be ignored after that.
REQ-014 FREE: start_in=1 and annul_in=0 SHALL go to BY_ZERO if opdata2_in==0 (DIV_ZERO_FAST_EN only), else to ON; otherwise SHALL stay in FREE.
REQ-015 FREE: annul_in=1 SHALL win over start_in, and the FSM SHALL stay in FREE.
REQ-016 ON: each edge SHALL perform one restoring-division step on magnitudes (shift, trial-subtract, set quotient bit) and increment the counter.
REQ-017 ON: the edge that performs step 32 (counter==31) SHALL go to END.
REQ-018 ON: an edge with annul_in=1 or start_in=0 SHALL go to FREE, with ready_out=0 and result_out unchanged (0).
REQ-019 Signed mode SHALL take absolute values of the operands before iterating.
REQ-020 Signed mode SHALL negate the quotient when the operand signs differ.
REQ-021 Signed mode SHALL give the remainder the sign of the dividend; the sign fix SHALL be applied on the ON->END edge.
REQ-022 Signed mode SHALL produce result_out for 0x80000000 / 0xFFFFFFFF equal to the two's-complement wrap: quotient 0x80000000, remainder 0.
REQ-023 BY_ZERO SHALL go to END on the next edge with result_out=0, unless annul_in=1, in which case it SHALL go to FREE.
REQ-024 END SHALL register ready_out=1 and the final result_out.
REQ-025 END SHALL stay in END while start_in=1 and SHALL go to FREE when start_in=0, clearing ready_out and result_out to 0 on that edge.
REQ-026 SHALL assert ready_out exactly 33 edges after the start edge for normal operation, and 2 edges after it for the BY_ZERO path.
REQ-027 stall_req_out SHALL be combinational = (FREE & start_in & ~annul_in) | ON | BY_ZERO; it SHALL be 0 in END.
REQ-028 result_out and ready_out SHALL be registered, with no combinational path from any input.

Reset
REQ-029 rst_n=0 SHALL asynchronously force: state FREE, counter 0, internal dividend/divisor registers 0, result_out 0, ready_out 0.
REQ-030 stall_req_out SHALL be 0 while rst_n=0.
REQ-031 Reset mid-operation SHALL discard the operation, and the first start_in after release SHALL run normally.

Configuration
REQ-032 Macro DIV_ZERO_FAST_EN, defined: a zero divisor SHALL take the BY_ZERO path, with result_out=0 and ready_out after 2 edges.
REQ-033 Macro DIV_ZERO_FAST_EN, undefined: BY_ZERO SHALL be unreachable, and a zero divisor SHALL run the full 32 steps.
REQ-034 With DIV_ZERO_FAST_EN undefined, unsigned divide by zero SHALL give quotient 0xFFFFFFFF and remainder = dividend, with the signed fix per REQ-019 to REQ-021 applied.

Verification
REQ-035 SHALL cover: DIVU 100/7, start held -> stall_req_out=1 for 33 cycles, ready_out at edge 33, result_out=0x00000002_0000000E; drop start -> ready_out=0, result_out=0 next edge.
REQ-036 SHALL cover: DIV -7/2 -> result_out=0xFFFFFFFF_FFFFFFFD; DIV 7/-2 -> 0x00000001_FFFFFFFD.
REQ-037 SHALL cover: DIVU 5/0 with macro on -> ready_out at edge 2, result_out=0; with macro off -> ready_out at edge 33, result_out=0x00000005_FFFFFFFF.
REQ-038 SHALL cover: annul_in pulsed on the 10th ON cycle -> FREE next edge, ready_out never asserts; a new start next cycle with 9/3 -> 0x00000000_00000003.
REQ-039 SHALL cover: rst_n low for 1 cycle mid-ON -> all outputs 0 immediately; restart 0xFFFFFFFF/1 unsigned -> 0x00000000_FFFFFFFF.
REQ-040 SHALL cover: start_in and annul_in both high in FREE -> state stays FREE, stall_req_out=0.
